// File: rtl/shift_mix_columns.sv
// AES round stage: ShiftRows followed by iterative MixColumns (COLS_PER_CYCLE columns per clock).
// In the last round the stage applies ShiftRows only and responds one edge after the request.
module shift_mix_columns #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         startTransition,
    input  logic         lastRound,
    input  logic [127:0] stateIn,
    output logic [127:0] stateOut,
    output logic         busy,
    output logic         doneTransition
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("shift_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

    typedef enum logic {IDLE, MIX} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte k = 4c + r lives at [127-8k -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    state_t         r_state;
    logic [127:0]   r_work;
    logic [127:0]   r_state_out;
    logic [2:0]     r_cnt;
    logic           r_busy;
    logic           r_done;

    logic [127:0]   w_shift;
    logic [127:0]   w_mix_next;
    logic [2:0]     w_cnt_next;

    assign w_shift    = shift_rows(stateIn);
    assign w_cnt_next = r_cnt + STEP;

    // Only COLS_PER_CYCLE mixers exist; they are steered onto the columns selected by the counter.
    always_comb begin
        w_mix_next = r_work;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            w_mix_next[(3 - int'(r_cnt[1:0]) - j) * 32 +: 32] =
                mix_col(r_work[(3 - int'(r_cnt[1:0]) - j) * 32 +: 32]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_state_out <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (startTransition) begin
                        r_work <= w_shift;
                        r_cnt  <= '0;
                        if (lastRound) begin
                            r_state_out <= w_shift;
                            r_done      <= 1'b1;
                        end else begin
                            r_state <= MIX;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                MIX: begin
                    r_work <= w_mix_next;
                    r_cnt  <= w_cnt_next;
                    if (w_cnt_next == 3'd4) begin
                        r_state_out <= w_mix_next;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stateOut       = r_state_out;
    assign busy           = r_busy;
    assign doneTransition = r_done;

endmodule

// File: tb/tb_shift_mix_columns.sv
// Directed bench for shift_mix_columns: three instances (1, 2, 4 columns per cycle) share one stimulus.
module tb_shift_mix_columns;

    typedef struct {
        logic [127:0] din;
        logic         last;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         startTransition;
    logic         lastRound;
    logic [127:0] stateIn;
    logic [127:0] so [3];
    logic         bz [3];
    logic         dn [3];

    int checks = 0;
    int errors = 0;
    int cpc   [3] = '{1, 2, 4};
    int mixlat[3] = '{5, 3, 2};

    localparam logic [127:0] V1_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] V1_MIX = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] V1_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] JUNK   = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] ONES   = {16{8'h01}};

    always #5 clk = ~clk;

    shift_mix_columns #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .reset(reset), .startTransition(startTransition), .lastRound(lastRound),
        .stateIn(stateIn), .stateOut(so[0]), .busy(bz[0]), .doneTransition(dn[0]));
    shift_mix_columns #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .reset(reset), .startTransition(startTransition), .lastRound(lastRound),
        .stateIn(stateIn), .stateOut(so[1]), .busy(bz[1]), .doneTransition(dn[1]));
    shift_mix_columns #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .reset(reset), .startTransition(startTransition), .lastRound(lastRound),
        .stateIn(stateIn), .stateOut(so[2]), .busy(bz[2]), .doneTransition(dn[2]));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One request; inputs change right after the accept edge to show they are not re-sampled.
    task automatic run_vec(input int idx, input vec_t v);
        int           lat  [3];
        int           nd   [3];
        logic [127:0] outv [3];
        logic         bseen[3];
        for (int k = 0; k < 3; k++) begin
            lat[k] = 0; nd[k] = 0; outv[k] = '0; bseen[k] = 1'b0;
        end
        @(negedge clk);
        stateIn = v.din; lastRound = v.last; startTransition = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                startTransition = 1'b0; stateIn = JUNK; lastRound = ~v.last;
            end
            for (int k = 0; k < 3; k++) begin
                if (bz[k]) bseen[k] = 1'b1;
                if (dn[k]) begin
                    nd[k]++;
                    lat[k] = cyc;
                    outv[k] = so[k];
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("v%0d C%0d stateOut", idx, cpc[k]), outv[k], v.exp);
            chk($sformatf("v%0d C%0d latency", idx, cpc[k]), 128'(lat[k]),
                128'(v.last ? 1 : mixlat[k]));
            chk($sformatf("v%0d C%0d done count", idx, cpc[k]), 128'(nd[k]), 128'd1);
            if (v.last)
                chk($sformatf("v%0d C%0d busy seen", idx, cpc[k]), 128'(bseen[k]), 128'd0);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   cnt[3], first[3], lastc[3];
        int   exp_cnt[3]  = '{4, 6, 10};
        int   exp_last[3] = '{20, 18, 20};

        vecs[0] = '{din: V1_IN,              last: 1'b0, exp: V1_MIX};
        vecs[1] = '{din: V1_IN,              last: 1'b1, exp: V1_SR};
        vecs[2] = '{din: {4{32'hdb135345}}, last: 1'b0, exp: {4{32'h8e4da1bc}}};
        vecs[3] = '{din: ONES,              last: 1'b0, exp: ONES};
        vecs[4] = '{din: {16{8'hc6}},       last: 1'b0, exp: {16{8'hc6}}};
        vecs[5] = '{din: {4{32'hdb135345}}, last: 1'b1, exp: {4{32'hdb135345}}};

        reset = 1'b1; startTransition = 1'b1; lastRound = 1'b1; stateIn = V1_IN;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset C%0d stateOut", cpc[k]), so[k], 128'h0);
            chk($sformatf("reset C%0d busy", cpc[k]), 128'(bz[k]), 128'd0);
            chk($sformatf("reset C%0d done", cpc[k]), 128'(dn[k]), 128'd0);
        end
        reset = 1'b0; startTransition = 1'b0; lastRound = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Start held high: back-to-back accepts in every done cycle.
        for (int k = 0; k < 3; k++) begin cnt[k] = 0; first[k] = 0; lastc[k] = 0; end
        stateIn = V1_IN; lastRound = 1'b0; startTransition = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (dn[k]) begin
                cnt[k]++;
                if (first[k] == 0) first[k] = cyc;
                lastc[k] = cyc;
            end
        end
        startTransition = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("held C%0d pulses", cpc[k]), 128'(cnt[k]), 128'(exp_cnt[k]));
            chk($sformatf("held C%0d first", cpc[k]), 128'(first[k]), 128'(mixlat[k]));
            chk($sformatf("held C%0d last", cpc[k]), 128'(lastc[k]), 128'(exp_last[k]));
            chk($sformatf("held C%0d stateOut", cpc[k]), so[k], V1_MIX);
        end

        // Second start during MIX: ignored for C1/C2, lands in the done cycle for C4.
        for (int k = 0; k < 3; k++) cnt[k] = 0;
        @(negedge clk);
        stateIn = V1_IN; lastRound = 1'b0; startTransition = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) startTransition = 1'b0;
            if (cyc == 2) begin startTransition = 1'b1; stateIn = ONES; end
            if (cyc == 3) startTransition = 1'b0;
            for (int k = 0; k < 3; k++) if (dn[k]) cnt[k]++;
        end
        chk("ignore C1 pulses", 128'(cnt[0]), 128'd1);
        chk("ignore C1 stateOut", so[0], V1_MIX);
        chk("ignore C2 pulses", 128'(cnt[1]), 128'd1);
        chk("ignore C2 stateOut", so[1], V1_MIX);
        chk("b2b C4 pulses", 128'(cnt[2]), 128'd2);
        chk("b2b C4 stateOut", so[2], ONES);

        // Reset in the middle of MIX aborts without a done pulse.
        for (int k = 0; k < 3; k++) cnt[k] = 0;
        @(negedge clk);
        stateIn = V1_IN; lastRound = 1'b0; startTransition = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) startTransition = 1'b0;
            if (cyc == 2) reset = 1'b1;
            if (cyc == 3) begin
                chk("midreset C1 stateOut", so[0], 128'h0);
                chk("midreset C1 busy", 128'(bz[0]), 128'd0);
                reset = 1'b0;
            end
            for (int k = 0; k < 2; k++) if (dn[k]) cnt[k]++;
        end
        chk("midreset C1 pulses", 128'(cnt[0]), 128'd0);
        chk("midreset C2 pulses", 128'(cnt[1]), 128'd0);
        run_vec(6, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_mix_columns.md
Name: shift_mix_columns

Overview:
Round stage directly downstream of the parallel SubByte stage in the AES encryption datapath. Consumes the 128-bit substituted state, applies ShiftRows, then MixColumns, and presents the new state to the AddRoundKey stage. MixColumns is computed iteratively, COLS_PER_CYCLE columns per clock, to trade latency for area. In the final AES round, MixColumns is bypassed.

Parameters:
COLS_PER_CYCLE, 1, columns mixed per clock; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
startTransition  input  1  request; stateIn is sampled on the edge where this is high and the block is idle
lastRound  input  1  sampled with stateIn; 1 = ShiftRows only, no MixColumns
stateIn  input  128  substituted state from the SubByte stage
stateOut  output  128  registered result; held stable until the next accepted request
busy  output  1  high while a request is in progress; requests are ignored while high
doneTransition  output  1  single-cycle pulse; stateOut is valid in this cycle and afterwards

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Byte order: byte k (k = 0..15) is bits [127-8k -: 8]. Row r = k mod 4, column c = k div 4, so columns are packed column-major, matching FIPS-197 input order.
- ShiftRows: out(r,c) = in(r, (c+r) mod 4).
- MixColumns, per column (a0..a3) -> (b0..b3), in GF(2^8):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00); 3x = xtime(x)^x.
- Reset: state IDLE, stateOut = 128'h0, busy = 0, doneTransition = 0, column counter = 0. Reset overrides every other input on the same edge.
- FSM states: IDLE, MIX.
- IDLE with startTransition = 1 (edge E0):
  - The working register loads ShiftRows(stateIn).
  - If lastRound = 1: stateOut takes the shifted value, doneTransition = 1 next cycle, FSM stays in IDLE. Latency is 1 edge.
  - Otherwise: FSM goes to MIX, busy = 1, column counter = 0.
- MIX: each edge replaces columns counter .. counter+COLS_PER_CYCLE-1 of the working register with their mixed values, then adds COLS_PER_CYCLE to the counter.
- Final MIX edge (counter + COLS_PER_CYCLE = 4): stateOut takes the completed register, doneTransition = 1 for the following cycle, busy = 0, FSM returns to IDLE.
  - Total latency from E0 to the done pulse is 1 + 4/COLS_PER_CYCLE edges: 5, 3 or 2.
- doneTransition is high for exactly one cycle per accepted request.
- startTransition while busy: ignored. No queuing, and stateIn and lastRound are not sampled.
- startTransition in the same cycle doneTransition is high: accepted, since the FSM is already IDLE. stateOut keeps the previous result until the new request completes; it is not updated with partial columns.
- The column counter never wraps past 4; it is reset to 0 on every accept.
- Reset mid-operation: the current request is aborted and no done pulse is emitted.
- stateIn is not required to be stable after E0.

Test Plan:
- FIPS-197 App. B round 1, COLS_PER_CYCLE=1: stateIn = d42711aee0bf98f1b8b45de51e415230, lastRound = 0 -> done pulse 5 edges after start; stateOut = 046681e5e0cb199a48f8d37a2806264c.
- Same input with lastRound = 1 -> done pulse after 1 edge; stateOut = d4bf5d30e0b452aeb84111f11e2798e5, busy never asserted.
- MixColumns column checks: state with every column db135345 and all rows equal, so ShiftRows is an identity -> each column becomes 8e4da1bc. All bytes 01 -> unchanged. All bytes c6 -> unchanged.
- Repeat test 1 with COLS_PER_CYCLE = 2 and 4 -> identical stateOut, with done after 3 and 2 edges respectively.
- Protocol:
  - Start pulses held high continuously -> exactly one done pulse per 5 cycles.
  - Start pulse raised at cycle 2 of MIX with a different stateIn -> ignored; the result matches the first input.
  - Back-to-back start in the done cycle -> accepted.
- Reset asserted during MIX (COLS_PER_CYCLE = 1) -> next cycle stateOut = 0, busy = 0, no done pulse. A fresh request afterwards completes correctly.
